// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam unsigned multiplier: one product column per clock,
// counting the ones among that column's crosswise partial products plus the running carry.
module vedic_mult_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);
    localparam int CW  = $clog2(W) + 2;
    localparam int CLW = $clog2(2 * W);
    localparam logic [CLW-1:0] LAST_COL = CLW'(2 * W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [CW-1:0]  carry;
    logic [CLW-1:0] col;
    logic [CW-1:0]  pp;
    logic [CW:0]    s;

    // Crosswise terms of column col: every pair (i, j) with i + j == col
    always_comb begin
        pp = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (col == CLW'(i + j))
                    pp = pp + CW'(ra[i] & rb[j]);
            end
        end
    end

    assign s = {1'b0, pp} + {1'b0, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            carry <= '0;
            col   <= '0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        p     <= '0;
                        carry <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    p[col] <= s[0];
                    carry  <= s[CW:1];
                    col    <= col + CLW'(1);
                    if (col == LAST_COL) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The top column has no terms, so anything left in the carry there is a lost product bit
    always_ff @(posedge clk) begin
        if (!rst && state == RUN && col == LAST_COL)
            assert (s[CW:1] == '0);
    end

endmodule

// File: doc/vedic_mult_seq.md
# vedic_mult_seq

Sequential, parametrised Urdhva-Tiryagbhyam (vertical-and-crosswise) unsigned multiplier. It computes one product column per clock: it counts the ones among that column's crosswise partial products, adds the running carry, emits one product bit and keeps the remaining bits as carry. It generalises the fixed 4-bit combinational Vedic multiplier and its 3-bit column adders to any operand width. It trades latency for area and adds a start/busy/done handshake, so it can sit beside other datapath blocks as a multi-cycle arithmetic unit.

## Interface
Parameters:
- W, default 8: operand width in bits; legal range 2..32.
- CW, derived as $clog2(W)+2 (not overridable): carry register width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a multiply; sampled only in IDLE.
- a, input, W: multiplicand; sampled on the accepted start.
- b, input, W: multiplier; sampled on the accepted start.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse; p is final in this cycle.
- p, output, 2W: product a*b, unsigned.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE: if start=1, the block latches a and b into internal registers ra and rb. It also sets p to 0, carry to 0 and col to 0, then moves to RUN. If start=0, it holds and p keeps its last value.
- RUN, column k=col (k runs 0..2W-1):
  - pp_k = sum over i of (ra[i] & rb[k-i]), for every i with 0<=i<W and 0<=k-i<W. The term count is min(k, 2W-2-k)+1 for k<=2W-2 and 0 for k=2W-1.
  - s = pp_k + carry, computed at CW+1 bits. It must never overflow, because carry stays below W.
  - p[k] <= s[0]; carry <= s >> 1; col <= col+1.
  - When col = 2W-1, the block writes p[2W-1] and moves to DONE. The carry at that point is 0 by construction. A verification assertion checks this.
- DONE: done=1 for exactly this cycle, then the block returns to IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored. Operands cannot be changed mid-operation because ra and rb are private copies.
- During RUN, p is partially written: bits below col are final, bits at col and above are 0. Consumers use p only on done or afterwards in IDLE.
- p holds its value in IDLE until the next accepted start clears it.
- Boundary cases:
  - a=0 or b=0 gives p=0.
  - a=b=2^W-1 gives p=2^(2W)-2^(W+1)+1; this is the maximum column count and maximum carry.
  - W=2 must work.

## Timing
- Reset values: busy=0, done=0, p=0, carry=0, col=0, state=IDLE.
- A start accepted at edge t puts the block in RUN from t+1. The last column is written at edge t+2W and done is high in cycle t+2W+1. Start-to-done latency is therefore 2W+1 cycles; for W=8 that is 17.
- busy is high for exactly 2W cycles.
- Throughput: one multiply per 2W+2 cycles. The earliest next start is accepted in the first IDLE cycle after done.
- rst asserted in any state, including mid-RUN, takes effect at the next edge. After that edge all outputs hold their reset values and the partial result is discarded. A start sampled together with rst is ignored.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then W=8 with a=0x0D, b=0x0B, start pulsed for 1 cycle -> busy high for 16 cycles, done exactly 17 cycles after start, p=0x008F held in IDLE afterwards.
- W=8 with a=0xFF, b=0xFF -> p=0xFE01 on done; the internal carry is 0 at the end of column 15.
- W=8 with a=0x00, b=0xA5, then a=0x01, b=0xA5 back-to-back, second start in the first IDLE cycle after done -> p=0x0000, then p=0x00A5; no cycles lost between operations.
- W=8 with a=0x12, b=0x34, start held high and a/b changed to 0xFF during RUN -> p=0x03A8; only one done pulse; the held start is re-accepted on the first IDLE cycle.
- W=8 with rst asserted 5 cycles into RUN -> next cycle busy=0, done=0, p=0; no done pulse follows; a fresh start with a=0x03, b=0x05 gives p=0x000F.
- W=4 with a=0xF, b=0xF -> p=0xE1 with done 9 cycles after start. Also run a randomized check against a*b of 1000 vectors, each for W=4, W=8 and W=16.
